// File: rtl/wb_bus_decoder.sv
// Wishbone B3 classic single-master to 4-slave address decoder.
// Unmapped or unanswered cycles complete with an error-data ack so the master never stalls.
module wb_bus_decoder #(
    parameter logic [127:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [127:0] SLV_MASK = {4{32'hF000_0000}},
    parameter int unsigned  TIMEOUT  = 255,
    parameter logic [31:0]  ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    output logic [31:0]  wbs_dat_o,
    output logic         wbs_ack_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [3:0]   wbm_stb_o,
    output logic [3:0]   wbm_cyc_o,
    input  logic [127:0] wbm_dat_i,
    input  logic [3:0]   wbm_ack_i,
    output logic         bus_err_o,
    output logic [31:0]  err_adr_o
);
    localparam int NSLV = 4;

    typedef enum logic [1:0] {IDLE, FWD, ERR, RECOVER} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  slot, slot_n, hit_idx;
    logic        hit;
    logic [3:0]  stb, stb_n;
    logic [31:0] adr, adr_n, wdat, wdat_n, rdat, rdat_n, eadr, eadr_n;
    logic        we, we_n, ack, ack_n, err, err_n;
    logic [3:0]  sel, sel_n;
    logic [31:0] slot_dat;

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((wbs_adr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    assign slot_dat = wbm_dat_i[{slot, 5'd0} +: 32];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        slot_n  = slot;
        stb_n   = stb;
        adr_n   = adr;
        wdat_n  = wdat;
        we_n    = we;
        sel_n   = sel;
        rdat_n  = rdat;
        eadr_n  = eadr;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_n  = wbs_adr_i;
                    wdat_n = wbs_dat_i;
                    we_n   = wbs_we_i;
                    sel_n  = wbs_sel_i;
                    if (hit) begin
                        state_n = FWD;
                        stb_n   = 4'b0001 << hit_idx;
                        slot_n  = hit_idx;
                        cnt_n   = '0;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            FWD: begin
                if (!wbs_cyc_i) begin
                    stb_n   = '0;
                    state_n = IDLE;
                end else if (wbm_ack_i[slot]) begin
                    // Ack beats a coincident timeout.
                    rdat_n  = slot_dat;
                    ack_n   = 1'b1;
                    stb_n   = '0;
                    state_n = RECOVER;
                end else if (cnt == 8'(TIMEOUT)) begin
                    rdat_n  = ERR_DATA;
                    ack_n   = 1'b1;
                    err_n   = 1'b1;
                    eadr_n  = adr;
                    stb_n   = '0;
                    state_n = RECOVER;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ERR: begin
                rdat_n  = ERR_DATA;
                ack_n   = 1'b1;
                err_n   = 1'b1;
                eadr_n  = adr;
                state_n = RECOVER;
            end
            RECOVER: begin
                // Wait for the master to drop stb so a lingering strobe is not re-issued.
                if (!wbs_stb_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            slot  <= '0;
            stb   <= '0;
            adr   <= '0;
            wdat  <= '0;
            we    <= 1'b0;
            sel   <= '0;
            rdat  <= '0;
            eadr  <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            slot  <= slot_n;
            stb   <= stb_n;
            adr   <= adr_n;
            wdat  <= wdat_n;
            we    <= we_n;
            sel   <= sel_n;
            rdat  <= rdat_n;
            eadr  <= eadr_n;
            ack   <= ack_n;
            err   <= err_n;
        end
    end

    assign wbs_dat_o = rdat;
    assign wbs_ack_o = ack;
    assign wbm_adr_o = adr;
    assign wbm_dat_o = wdat;
    assign wbm_we_o  = we;
    assign wbm_sel_o = sel;
    assign wbm_stb_o = stb;
    assign wbm_cyc_o = stb;
    assign bus_err_o = err;
    assign err_adr_o = eadr;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed bench for wb_bus_decoder: a per-cycle expectation timeline built from
// transaction-level rules, compared against the DUT on every falling edge.
module tb_wb_bus_decoder;
    localparam int          TO   = 8;
    localparam int          NC   = 2000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic         clk = 1'b0, rst = 1'b1;
    logic [31:0]  adr_i = '0, dat_i = '0;
    logic         we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic [3:0]   sel_i = '0;
    logic [127:0] sdat = '0;
    logic [3:0]   sack = '0;

    logic [31:0]  dat_o, madr, mdat, eadr_o;
    logic         ack_o, mwe, berr;
    logic [3:0]   msel, mstb, mcyc;

    int vecs = 0, errs = 0, cyc = 0;
    int ack_cnt = 0, err_cnt = 0, stb_starts = 0;
    logic [3:0] stb_prev = '0;

    logic [3:0]  e_stb  [NC];
    logic        e_ack  [NC];
    logic        e_err  [NC];
    logic [31:0] e_rdat [NC];
    logic [31:0] e_eadr [NC];
    logic [31:0] e_adr  [NC];
    logic [31:0] e_wdat [NC];
    logic        e_we   [NC];
    logic [3:0]  e_sel  [NC];

    wb_bus_decoder #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
        .wbs_stb_i(stb_i), .wbs_cyc_i(cyc_i),
        .wbs_dat_o(dat_o), .wbs_ack_o(ack_o),
        .wbm_adr_o(madr), .wbm_dat_o(mdat), .wbm_we_o(mwe), .wbm_sel_o(msel),
        .wbm_stb_o(mstb), .wbm_cyc_o(mcyc),
        .wbm_dat_i(sdat), .wbm_ack_i(sack),
        .bus_err_o(berr), .err_adr_o(eadr_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < NC; i++) begin
            e_stb[i] = '0; e_ack[i] = 1'b0; e_err[i] = 1'b0; e_rdat[i] = '0; e_eadr[i] = '0;
            e_adr[i] = '0; e_wdat[i] = '0; e_we[i] = 1'b0; e_sel[i] = '0;
        end
    endtask

    task automatic hold_from(input int c, input logic [31:0] a, input logic [31:0] wd,
                             input logic w, input logic [3:0] s);
        for (int i = c; i < NC; i++) begin
            e_adr[i] = a; e_wdat[i] = wd; e_we[i] = w; e_sel[i] = s;
        end
    endtask

    // One CPU request. d = slave ack delay in cycles after its strobe first shows
    // (d > TO means the slave never answers); hold = cycles the master keeps stb after ack.
    task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] s, input int d, input logic [31:0] sd,
                        input logic [3:0] noise, input int hold);
        int t0, slot, k, ca;
        logic hit, bad;
        slot = int'(a[31:28]);
        hit  = (slot < 4);
        for (int i = 0; i < 4; i++)
            sdat[32*i +: 32] = (hit && i == slot) ? sd : (32'hC0DE_0000 + 32'(i));
        adr_i = a; dat_i = wd; we_i = w; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
        t0 = cyc + 1;
        hold_from(t0, a, wd, w, s);
        bad = !hit || (d > TO);
        if (hit) begin
            k = (d <= TO) ? d : TO;
            for (int c = t0; c <= t0 + k; c++) e_stb[c] = 4'(1 << slot);
            ca = t0 + k + 1;
        end else begin
            ca = t0 + 1;
        end
        e_ack[ca] = 1'b1;
        e_err[ca] = bad;
        for (int i = ca; i < NC; i++) begin
            e_rdat[i] = bad ? DEAD : sd;
            if (bad) e_eadr[i] = a;
        end
        do begin
            tick();
            sack = '0;
            if (hit && d <= TO && cyc == t0 + d) sack[slot] = 1'b1;
            if (cyc == t0) sack = sack | (noise & ~4'(1 << slot));
        end while (cyc < ca + hold);
        sack = '0;
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cyc < NC) begin
                    chk("wbm_stb", 32'(mstb), 32'(e_stb[cyc]));
                    chk("wbm_cyc", 32'(mcyc), 32'(e_stb[cyc]));
                    chk("wbs_ack", 32'(ack_o), 32'(e_ack[cyc]));
                    chk("bus_err", 32'(berr), 32'(e_err[cyc]));
                    chk("wbs_dat", dat_o, e_rdat[cyc]);
                    chk("err_adr", eadr_o, e_eadr[cyc]);
                    chk("wbm_adr", madr, e_adr[cyc]);
                    chk("wbm_dat", mdat, e_wdat[cyc]);
                    chk("wbm_we", 32'(mwe), 32'(e_we[cyc]));
                    chk("wbm_sel", 32'(msel), 32'(e_sel[cyc]));
                end
                if (ack_o) ack_cnt++;
                if (berr) err_cnt++;
                if (mstb != 4'b0 && stb_prev == 4'b0) stb_starts++;
                stb_prev = mstb;
            end
        end
    end

    initial begin
        int t0, b_ack, b_stb;
        clear_from(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stb", 32'(mstb), 32'h0);
        chk("rst_cyc", 32'(mcyc), 32'h0);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_err", 32'(berr), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_eadr", eadr_o, 32'h0);
        chk("rst_adr", madr, 32'h0);
        rst = 1'b0;

        // Slave 1 read, with a stray ack on slot 2 that must be ignored.
        xact(32'h1000_0010, 1'b0, 32'h0, 4'hF, 1, 32'h1234_5678, 4'b0100, 1);
        chk("t1_rdata", dat_o, 32'h1234_5678);
        chk("t1_acks", 32'(ack_cnt), 32'd1);
        chk("t1_stbs", 32'(stb_starts), 32'd1);
        chk("t1_errs", 32'(err_cnt), 32'd0);

        // Slave 0 write.
        xact(32'h0000_0040, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0000_5A5A, 4'b0000, 1);
        chk("t2_we", 32'(mwe), 32'd1);
        chk("t2_sel", 32'(msel), 32'h3);
        chk("t2_wdat", mdat, 32'hA5A5_A5A5);
        chk("t2_errs", 32'(err_cnt), 32'd0);
        chk("t2_acks", 32'(ack_cnt), 32'd2);

        // Unmapped read.
        xact(32'h8000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 4'b0000, 1);
        chk("t3_rdata", dat_o, 32'hDEAD_BEEF);
        chk("t3_eadr", eadr_o, 32'h8000_0000);
        chk("t3_errs", 32'(err_cnt), 32'd1);
        chk("t3_stbs", 32'(stb_starts), 32'd2);

        // Slave 2 silent -> timeout; then ack exactly on the timeout cycle.
        xact(32'h2000_0020, 1'b0, 32'h0, 4'hF, 1000, 32'h0, 4'b0000, 1);
        chk("t4_rdata", dat_o, 32'hDEAD_BEEF);
        chk("t4_eadr", eadr_o, 32'h2000_0020);
        chk("t4_errs", 32'(err_cnt), 32'd2);
        xact(32'h2000_0024, 1'b0, 32'h0, 4'hF, TO, 32'h2222_0008, 4'b0000, 1);
        chk("t5_rdata", dat_o, 32'h2222_0008);
        chk("t5_errs", 32'(err_cnt), 32'd2);
        chk("t5_eadr", eadr_o, 32'h2000_0020);

        // Master abort while forwarding.
        b_ack = ack_cnt;
        adr_i = 32'h0000_0080; dat_i = '0; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        t0 = cyc + 1;
        hold_from(t0, 32'h0000_0080, 32'h0, 1'b0, 4'hF);
        for (int c = t0; c <= t0 + 2; c++) e_stb[c] = 4'b0001;
        while (cyc < t0 + 2) tick();
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
        tick();
        chk("abort_acks", 32'(ack_cnt - b_ack), 32'd0);
        chk("abort_errs", 32'(err_cnt), 32'd2);

        // Reset in the middle of a slave 3 access.
        adr_i = 32'h3000_0000; cyc_i = 1'b1; stb_i = 1'b1;
        t0 = cyc + 1;
        hold_from(t0, 32'h3000_0000, 32'h0, 1'b0, 4'hF);
        for (int c = t0; c <= t0 + TO; c++) e_stb[c] = 4'b1000;
        while (cyc < t0 + 2) tick();
        #1;
        rst = 1'b1;
        clear_from(cyc);
        #1;
        chk("mid_rst_stb", 32'(mstb), 32'h0);
        chk("mid_rst_cyc", 32'(mcyc), 32'h0);
        chk("mid_rst_ack", 32'(ack_o), 32'h0);
        chk("mid_rst_eadr", eadr_o, 32'h0);
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        xact(32'h3000_0004, 1'b0, 32'h0, 4'hF, 1, 32'h3333_0004, 4'b0000, 1);
        chk("t6_rdata", dat_o, 32'h3333_0004);
        chk("t6_eadr", eadr_o, 32'h0);

        // Back-to-back requests with stb lingering a cycle past each ack.
        b_ack = ack_cnt;
        b_stb = stb_starts;
        xact(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1, 32'h0101_0101, 4'b0000, 2);
        xact(32'h1000_0200, 1'b0, 32'h0, 4'hF, 1, 32'h0202_0202, 4'b0000, 2);
        xact(32'h3000_0300, 1'b0, 32'h0, 4'hF, 1, 32'h0303_0303, 4'b0000, 2);
        xact(32'h5000_0000, 1'b1, 32'h5555_5555, 4'hF, 0, 32'h0, 4'b0000, 2);
        chk("b2b_acks", 32'(ack_cnt - b_ack), 32'd4);
        chk("b2b_stbs", 32'(stb_starts - b_stb), 32'd3);
        chk("b2b_eadr", eadr_o, 32'h5000_0000);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
